// File: rtl/motor_move_scheduler_if.sv
// Request and step-engine bundle between the request sources, the scheduler and the step engine.
interface motor_move_scheduler_if #(
    parameter int unsigned STEP_W = 16
);
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_axis;
    logic              host_req_dir;
    logic [STEP_W-1:0] host_req_steps;

    logic              trk_req_valid;
    logic              trk_req_ready;
    logic              trk_req_axis;
    logic              trk_req_dir;
    logic [STEP_W-1:0] trk_req_steps;

    logic              eng_start;
    logic              eng_axis;
    logic              eng_dir;
    logic [STEP_W-1:0] eng_steps;
    logic              eng_done;

    // Scheduler side: consumes requests, commands the engine.
    modport slave (
        input  host_req_valid, host_req_axis, host_req_dir, host_req_steps,
        input  trk_req_valid, trk_req_axis, trk_req_dir, trk_req_steps,
        input  eng_done,
        output host_req_ready, trk_req_ready,
        output eng_start, eng_axis, eng_dir, eng_steps
    );

    // Environment side: request sources and step engine.
    modport master (
        output host_req_valid, host_req_axis, host_req_dir, host_req_steps,
        output trk_req_valid, trk_req_axis, trk_req_dir, trk_req_steps,
        output eng_done,
        input  host_req_ready, trk_req_ready,
        input  eng_start, eng_axis, eng_dir, eng_steps
    );
endinterface

// File: rtl/motor_move_scheduler.sv
// Arbitrates host/tracker moves, clamps them to soft limits and sequences them onto one step engine.
module motor_move_scheduler #(
    parameter int unsigned STEP_W      = 16,
    parameter int unsigned POS_W       = 16,
    parameter int          POS_MIN     = -1000,
    parameter int          POS_MAX     = 1000,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                    FSM_Clk,
    input  logic                    Rst_n,
    motor_move_scheduler_if.slave   req,
    input  logic                    fault_clr,
    output logic signed [POS_W-1:0] pan_pos,
    output logic signed [POS_W-1:0] tilt_pos,
    output logic                    busy,
    output logic                    last_grant_host,
    output logic                    clamped,
    output logic                    fault,
    output logic [2:0]              State
);
    localparam int unsigned EXT_W   = ((POS_W > STEP_W) ? POS_W : STEP_W) + 2;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic signed [EXT_W-1:0] LIM_MIN = EXT_W'(POS_MIN);
    localparam logic signed [EXT_W-1:0] LIM_MAX = EXT_W'(POS_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLAMP  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_SETTLE = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               eng_start_q, eng_axis_q, eng_dir_q;
    logic [STEP_W-1:0]  eng_steps_q;

    logic               host_acc_c, trk_acc_c;
    logic signed [POS_W-1:0] pos_sel_c;
    logic signed [EXT_W-1:0] pos_ext_c, steps_ext_c, target_c;
    logic               clamp_hi_c, clamp_lo_c;
    logic [STEP_W-1:0]  clamp_steps_c;

    assign req.host_req_ready = (state_q == S_IDLE);
    assign req.trk_req_ready  = (state_q == S_IDLE) && !req.host_req_valid;
    assign host_acc_c         = req.host_req_valid && (state_q == S_IDLE);
    assign trk_acc_c          = req.trk_req_valid && req.trk_req_ready;

    assign req.eng_start = eng_start_q;
    assign req.eng_axis  = eng_axis_q;
    assign req.eng_dir   = eng_dir_q;
    assign req.eng_steps = eng_steps_q;
    assign State         = state_q;

    // Target position of the pending move and the limit-clamped step count; also the post-move position.
    always_comb begin
        pos_sel_c     = eng_axis_q ? tilt_pos : pan_pos;
        pos_ext_c     = {{(EXT_W-POS_W){pos_sel_c[POS_W-1]}}, pos_sel_c};
        steps_ext_c   = $signed(EXT_W'(eng_steps_q));
        target_c      = eng_dir_q ? (pos_ext_c + steps_ext_c) : (pos_ext_c - steps_ext_c);
        clamp_hi_c    = (target_c > LIM_MAX);
        clamp_lo_c    = (target_c < LIM_MIN);
        clamp_steps_c = eng_steps_q;
        if (clamp_hi_c) begin
            clamp_steps_c = STEP_W'(LIM_MAX - pos_ext_c);
        end else if (clamp_lo_c) begin
            clamp_steps_c = STEP_W'(pos_ext_c - LIM_MIN);
        end
    end

    // State register and shared wait/settle counter.
    always_ff @(posedge FSM_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (host_acc_c || trk_acc_c) state_d = S_CLAMP;
            end
            S_CLAMP: state_d = (clamp_steps_c == '0) ? S_IDLE : S_ISSUE;
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (req.eng_done) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FAULT: if (fault_clr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs, captured request fields and per-axis position tracking.
    always_ff @(posedge FSM_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            eng_start_q     <= 1'b0;
            eng_axis_q      <= 1'b0;
            eng_dir_q       <= 1'b0;
            eng_steps_q     <= '0;
            clamped         <= 1'b0;
            fault           <= 1'b0;
            busy            <= 1'b0;
            last_grant_host <= 1'b0;
            pan_pos         <= '0;
            tilt_pos        <= '0;
        end else begin
            eng_start_q <= (state_d == S_ISSUE);
            busy        <= (state_d != S_IDLE);
            fault       <= (state_d == S_FAULT);
            clamped     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (host_acc_c) begin
                        eng_axis_q      <= req.host_req_axis;
                        eng_dir_q       <= req.host_req_dir;
                        eng_steps_q     <= req.host_req_steps;
                        last_grant_host <= 1'b1;
                    end else if (trk_acc_c) begin
                        eng_axis_q      <= req.trk_req_axis;
                        eng_dir_q       <= req.trk_req_dir;
                        eng_steps_q     <= req.trk_req_steps;
                        last_grant_host <= 1'b0;
                    end
                end
                S_CLAMP: begin
                    eng_steps_q <= clamp_steps_c;
                    clamped     <= clamp_hi_c || clamp_lo_c;
                end
                S_WAIT: begin
                    if (req.eng_done) begin
                        if (eng_axis_q) tilt_pos <= POS_W'(target_c);
                        else            pan_pos  <= POS_W'(target_c);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_motor_move_scheduler.sv
// Directed self-checking bench for motor_move_scheduler.
module tb_motor_move_scheduler;
    localparam int unsigned SETTLE  = 8;
    localparam int unsigned TIMEOUT = 40;

    logic               clk;
    logic               rst_n;
    logic               fault_clr;
    logic signed [15:0] pan_pos;
    logic signed [15:0] tilt_pos;
    logic               busy;
    logic               last_grant_host;
    logic               clamped;
    logic               fault;
    logic [2:0]         state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    motor_move_scheduler_if #(.STEP_W(16)) bus_if ();

    motor_move_scheduler #(
        .STEP_W(16), .POS_W(16), .POS_MIN(-1000), .POS_MAX(1000),
        .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .FSM_Clk(clk),
        .Rst_n(rst_n),
        .req(bus_if.slave),
        .fault_clr(fault_clr),
        .pan_pos(pan_pos),
        .tilt_pos(tilt_pos),
        .busy(busy),
        .last_grant_host(last_grant_host),
        .clamped(clamped),
        .fault(fault),
        .State(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns in the CLAMP cycle.
    task automatic accept(input bit from_host, input bit axis, input bit dir, input logic [15:0] steps);
        if (from_host) begin
            bus_if.host_req_valid = 1'b1;
            bus_if.host_req_axis  = axis;
            bus_if.host_req_dir   = dir;
            bus_if.host_req_steps = steps;
        end else begin
            bus_if.trk_req_valid = 1'b1;
            bus_if.trk_req_axis  = axis;
            bus_if.trk_req_dir   = dir;
            bus_if.trk_req_steps = steps;
        end
        @(negedge clk);
        bus_if.host_req_valid = 1'b0;
        bus_if.trk_req_valid  = 1'b0;
    endtask

    // From the CLAMP cycle: check issue, pulse eng_done 'dly' cycles after eng_start, check settle.
    task automatic finish_move(input string tag, input logic [15:0] exp_steps, input bit exp_clamped, input int dly);
        check({tag, ".clamp_state"}, 32'(state_dbg), 1);
        @(negedge clk);
        check({tag, ".eng_start"}, 32'(bus_if.eng_start), 1);
        check({tag, ".eng_steps"}, 32'(bus_if.eng_steps), 32'(exp_steps));
        check({tag, ".clamped"}, 32'(clamped), 32'(exp_clamped));
        @(negedge clk);
        check({tag, ".start_once"}, 32'(bus_if.eng_start), 0);
        check({tag, ".wait_state"}, 32'(state_dbg), 3);
        repeat (dly - 1) @(negedge clk);
        bus_if.eng_done = 1'b1;
        @(negedge clk);
        bus_if.eng_done = 1'b0;
        check({tag, ".settle_state"}, 32'(state_dbg), 4);
        repeat (SETTLE - 1) @(negedge clk);
        check({tag, ".busy_last_settle"}, 32'(busy), 1);
        @(negedge clk);
        check({tag, ".busy_clear"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        fault_clr = 1'b0;
        bus_if.host_req_valid = 1'b0; bus_if.host_req_axis = 1'b0;
        bus_if.host_req_dir = 1'b0;   bus_if.host_req_steps = '0;
        bus_if.trk_req_valid = 1'b0;  bus_if.trk_req_axis = 1'b0;
        bus_if.trk_req_dir = 1'b0;    bus_if.trk_req_steps = '0;
        bus_if.eng_done = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.state", 32'(state_dbg), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.eng_start", 32'(bus_if.eng_start), 0);
        check("rst.fault", 32'(fault), 0);
        check("rst.pan", 32'(pan_pos), 0);
        check("rst.tilt", 32'(tilt_pos), 0);
        check("rst.host_ready", 32'(bus_if.host_req_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic host pan move
        accept(1'b1, 1'b0, 1'b1, 16'd100);
        check("t1.grant", 32'(last_grant_host), 1);
        finish_move("t1", 16'd100, 1'b0, 20);
        check("t1.pan", 32'(pan_pos), 100);

        // Simultaneous requests: host tilt 10 wins, tracker pan 5 waits
        bus_if.host_req_valid = 1'b1; bus_if.host_req_axis = 1'b1;
        bus_if.host_req_dir = 1'b1;   bus_if.host_req_steps = 16'd10;
        bus_if.trk_req_valid = 1'b1;  bus_if.trk_req_axis = 1'b0;
        bus_if.trk_req_dir = 1'b1;    bus_if.trk_req_steps = 16'd5;
        #1;
        check("t2.trk_ready_blocked", 32'(bus_if.trk_req_ready), 0);
        @(negedge clk);
        bus_if.host_req_valid = 1'b0;
        check("t2.host_grant", 32'(last_grant_host), 1);
        check("t2.eng_axis", 32'(bus_if.eng_axis), 1);
        finish_move("t2h", 16'd10, 1'b0, 6);
        check("t2.trk_ready", 32'(bus_if.trk_req_ready), 1);
        @(negedge clk);
        bus_if.trk_req_valid = 1'b0;
        check("t2.trk_grant", 32'(last_grant_host), 0);
        finish_move("t2t", 16'd5, 1'b0, 3);
        check("t2.tilt", 32'(tilt_pos), 10);
        check("t2.pan", 32'(pan_pos), 105);

        // Upper limit clamp, then a fully clamped request
        accept(1'b1, 1'b0, 1'b1, 16'd885);
        finish_move("t3a", 16'd885, 1'b0, 3);
        check("t3.pan990", 32'(pan_pos), 990);
        accept(1'b1, 1'b0, 1'b1, 16'd50);
        finish_move("t3b", 16'd10, 1'b1, 5);
        check("t3.pan1000", 32'(pan_pos), 1000);
        accept(1'b1, 1'b0, 1'b1, 16'd50);
        check("t3c.busy_clamp", 32'(busy), 1);
        @(negedge clk);
        check("t3c.idle", 32'(state_dbg), 0);
        check("t3c.busy", 32'(busy), 0);
        check("t3c.no_start", 32'(bus_if.eng_start), 0);
        check("t3c.clamped", 32'(clamped), 1);
        check("t3c.pan", 32'(pan_pos), 1000);

        // Lower limit clamp on tilt from 0 via tracker
        accept(1'b1, 1'b1, 1'b0, 16'd10);
        finish_move("t4a", 16'd10, 1'b0, 2);
        check("t4.tilt0", 32'(tilt_pos), 0);
        accept(1'b0, 1'b1, 1'b0, 16'd1500);
        finish_move("t4b", 16'd1000, 1'b1, 4);
        check("t4.tilt_min", 32'(tilt_pos), -1000);
        check("t4.grant", 32'(last_grant_host), 0);

        // Timeout fault
        accept(1'b1, 1'b0, 1'b0, 16'd30);
        @(negedge clk);
        check("t5.eng_steps", 32'(bus_if.eng_steps), 30);
        repeat (TIMEOUT) @(negedge clk);
        check("t5.last_wait", 32'(state_dbg), 3);
        @(negedge clk);
        check("t5.state", 32'(state_dbg), 5);
        check("t5.fault", 32'(fault), 1);
        check("t5.host_ready", 32'(bus_if.host_req_ready), 0);
        check("t5.trk_ready", 32'(bus_if.trk_req_ready), 0);
        bus_if.eng_done = 1'b1;
        @(negedge clk);
        bus_if.eng_done = 1'b0;
        check("t5.late_done_pan", 32'(pan_pos), 1000);
        check("t5.still_fault", 32'(fault), 1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("t5.clr_state", 32'(state_dbg), 0);
        check("t5.clr_fault", 32'(fault), 0);
        check("t5.clr_ready", 32'(bus_if.host_req_ready), 1);
        check("t5.pan_kept", 32'(pan_pos), 1000);

        // Reset during WAIT
        accept(1'b1, 1'b1, 1'b1, 16'd5);
        repeat (4) @(negedge clk);
        check("t6.in_wait", 32'(state_dbg), 3);
        rst_n = 1'b0;
        #1;
        check("t6.state", 32'(state_dbg), 0);
        check("t6.busy", 32'(busy), 0);
        check("t6.eng_axis", 32'(bus_if.eng_axis), 0);
        check("t6.eng_steps", 32'(bus_if.eng_steps), 0);
        check("t6.pan", 32'(pan_pos), 0);
        check("t6.tilt", 32'(tilt_pos), 0);
        check("t6.grant", 32'(last_grant_host), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_if.eng_done = 1'b1;
        @(negedge clk);
        bus_if.eng_done = 1'b0;
        check("t6.stray_state", 32'(state_dbg), 0);
        check("t6.stray_tilt", 32'(tilt_pos), 0);
        check("t6.stray_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
